// File: rtl/registers.sv
// RV32I integer register file: 32 x 32-bit, two combinational read ports, one write port.
// x0 is hardwired to zero; an asynchronous active-low reset clears every register.
module registers (
    input  logic               clk,
    input  logic               rst_n,
    input  logic [4:0]         rs1,
    output logic signed [31:0] rs1_data_out,
    input  logic [4:0]         rs2,
    output logic signed [31:0] rs2_data_out,
    input  logic [4:0]         rd,
    input  logic               rd_write_enable,
    input  logic [31:0]        rd_data_in
);

    logic [31:0] r_regs [0:31];
    logic        w_writeHit;

    assign w_writeHit = rd_write_enable && (rd != 5'd0);

    // Entry 0 is cleared by reset and never written, so it always holds zero.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            for (int i = 0; i < 32; i++) begin
                r_regs[i] <= 32'h0000_0000;
            end
        end else if (w_writeHit) begin
            r_regs[rd] <= rd_data_in;
        end
    end

    // Reads are forced to zero while reset is held, and for x0, without any write bypass.
    always_comb begin
        rs1_data_out = 32'sh0000_0000;
        rs2_data_out = 32'sh0000_0000;
        if (rst_n && (rs1 != 5'd0)) begin
            rs1_data_out = r_regs[rs1];
        end
        if (rst_n && (rs2 != 5'd0)) begin
            rs2_data_out = r_regs[rs2];
        end
    end

endmodule

// File: tb/tb_registers.sv
// Self-checking bench for the register file: directed scenarios followed by
// randomized traffic compared against an array-based reference model.
module tb_registers;

    logic               clk;
    logic               rst_n;
    logic [4:0]         rs1;
    logic signed [31:0] rs1_data_out;
    logic [4:0]         rs2;
    logic signed [31:0] rs2_data_out;
    logic [4:0]         rd;
    logic               rd_write_enable;
    logic [31:0]        rd_data_in;

    int checks = 0;
    int errors = 0;
    logic [31:0] model [32];

    registers dut (
        .clk             (clk),
        .rst_n           (rst_n),
        .rs1             (rs1),
        .rs1_data_out    (rs1_data_out),
        .rs2             (rs2),
        .rs2_data_out    (rs2_data_out),
        .rd              (rd),
        .rd_write_enable (rd_write_enable),
        .rd_data_in      (rd_data_in)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [31:0] observed, input logic [31:0] expected);
        checks++;
        assert (observed === expected)
        else begin
            errors++;
            $error("[TB] FAIL %s observed %h expected %h", tag, observed, expected);
        end
    endtask

    // Advance past the next rising edge and mirror its effect in the model.
    task automatic tick();
        @(posedge clk);
        if (rst_n && rd_write_enable && rd != 5'd0) model[rd] = rd_data_in;
        #1;
    endtask

    task automatic clearModel();
        for (int i = 0; i < 32; i++) model[i] = 32'h0;
    endtask

    task automatic setWrite(input logic [4:0] idx, input logic [31:0] data, input logic en);
        rd = idx;
        rd_data_in = data;
        rd_write_enable = en;
    endtask

    initial begin
        rst_n = 1'b0;
        rs1 = 5'd0;
        rs2 = 5'd0;
        setWrite(5'd0, 32'h0, 1'b0);
        clearModel();

        // Reads during reset are zero, even with a write requested across edges.
        setWrite(5'd9, 32'hCAFE_F00D, 1'b1);
        rs1 = 5'd9;
        rs2 = 5'd17;
        tick();
        tick();
        check("resetRs1", rs1_data_out, 32'h0);
        check("resetRs2", rs2_data_out, 32'h0);
        setWrite(5'd0, 32'h0, 1'b0);
        #2 rst_n = 1'b1;
        #1;

        // Full index sweep after reset.
        for (int i = 0; i < 32; i++) begin
            rs1 = 5'(i);
            rs2 = 5'(31 - i);
            #1;
            check($sformatf("sweepRs1_%0d", i), rs1_data_out, 32'h0);
            check($sformatf("sweepRs2_%0d", 31 - i), rs2_data_out, 32'h0);
        end

        // First enabled edge after reset release performs a write.
        setWrite(5'd5, 32'hDEAD_BEEF, 1'b1);
        tick();
        setWrite(5'd31, 32'h8000_0001, 1'b1);
        tick();
        setWrite(5'd0, 32'h0, 1'b0);
        rs1 = 5'd5;
        rs2 = 5'd31;
        #1;
        check("x5", rs1_data_out, 32'hDEAD_BEEF);
        check("x31", rs2_data_out, 32'h8000_0001);
        rs2 = 5'd5;
        #1;
        check("sameIdxRs1", rs1_data_out, 32'hDEAD_BEEF);
        check("sameIdxRs2", rs2_data_out, 32'hDEAD_BEEF);

        // Writes to x0 are ignored.
        setWrite(5'd0, 32'hFFFF_FFFF, 1'b1);
        tick();
        rs1 = 5'd0;
        #1;
        check("x0Write", rs1_data_out, 32'h0);

        // Disabled write leaves x7 alone.
        setWrite(5'd7, 32'h1234_5678, 1'b0);
        tick();
        rs1 = 5'd7;
        #1;
        check("x7NoWrite", rs1_data_out, 32'h0);

        // Read during write returns old data until the edge.
        setWrite(5'd3, 32'h11, 1'b1);
        tick();
        setWrite(5'd3, 32'h22, 1'b1);
        rs1 = 5'd3;
        #1;
        check("rdwBefore", rs1_data_out, 32'h11);
        tick();
        setWrite(5'd0, 32'h0, 1'b0);
        check("rdwAfter", rs1_data_out, 32'h22);

        // Repeated enable rewrites the same value each edge.
        setWrite(5'd12, 32'h0BAD_F00D, 1'b1);
        tick();
        tick();
        tick();
        setWrite(5'd0, 32'h0, 1'b0);
        rs2 = 5'd12;
        #1;
        check("x12Hold", rs2_data_out, 32'h0BAD_F00D);

        // Randomized traffic against the model; reads checked before each edge.
        for (int n = 0; n < 300; n++) begin
            setWrite(5'($urandom_range(0, 31)), $urandom, ($urandom_range(0, 3) != 0));
            rs1 = 5'($urandom_range(0, 31));
            rs2 = ($urandom_range(0, 7) == 0) ? rs1 : 5'($urandom_range(0, 31));
            #1;
            check($sformatf("rand%0d_rs1_x%0d", n, rs1), rs1_data_out, model[rs1]);
            check($sformatf("rand%0d_rs2_x%0d", n, rs2), rs2_data_out, model[rs2]);
            tick();
        end
        setWrite(5'd0, 32'h0, 1'b0);

        // Fill every register, then assert reset between edges.
        for (int i = 1; i < 32; i++) begin
            setWrite(5'(i), 32'(i) * 32'h0101_0101, 1'b1);
            tick();
        end
        setWrite(5'd0, 32'h0, 1'b0);
        rs1 = 5'd20;
        #1;
        check("fillX20", rs1_data_out, 32'h1414_1414);
        @(negedge clk);
        rst_n = 1'b0;
        clearModel();
        #1;
        for (int i = 0; i < 32; i++) begin
            rs1 = 5'(i);
            rs2 = 5'(i ^ 5'h1F);
            #0.1;
            check($sformatf("midReset%0d", i), rs1_data_out, 32'h0);
            check($sformatf("midResetB%0d", i), rs2_data_out, 32'h0);
        end
        @(negedge clk);
        rst_n = 1'b1;
        #1;
        for (int i = 0; i < 32; i++) begin
            rs1 = 5'(i);
            #1;
            check($sformatf("postReset%0d", i), rs1_data_out, 32'h0);
        end

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

    // Guard against a stalled run.
    initial begin
        #200000;
        $display("[TB] FAIL timeout observed running expected finished");
        $fatal(1, "[TB] timeout");
    end

endmodule
